// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming 3-to-8 decoder.
package decoder_pkg;

   localparam int unsigned DEC_IN_W  = 3;
   localparam int unsigned DEC_OUT_W = 1 << DEC_IN_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   function automatic logic [DEC_OUT_W-1:0] onehot_of(input logic [DEC_IN_W-1:0] code);
      return DEC_OUT_W'(1) << code;
   endfunction

endpackage

// File: rtl/decoder3to8_stream_if.sv
// Code-in / one-hot-out stream bundle for decoder3to8_stream.
interface decoder3to8_stream_if
   import decoder_pkg::*;
#(
   parameter int unsigned IN_W = DEC_IN_W
) ();

   localparam int unsigned OUT_W = 1 << IN_W;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_code;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_onehot
   );

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_onehot
   );

endinterface

// File: rtl/dec_skid_buf2.sv
// Generic 2-entry skid buffer; in_ready depends only on state, never on out_ready.
module dec_skid_buf2
   import decoder_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   buf_state_e   state, state_nxt;
   logic [W-1:0] head, tail;
   logic         push, pop;

   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign out_data = head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (push) state_nxt = ONE;
         ONE: begin
            if (push && !pop)      state_nxt = FULL;
            else if (pop && !push) state_nxt = EMPTY;
         end
         FULL:    if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = (state != FULL);
      out_valid = (state != EMPTY);
      occupancy = 2'(state);
   end

   // Head is zeroed when the buffer drains so the idle output value needs no extra mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         case (state)
            EMPTY: if (push) head <= in_data;
            ONE: begin
               if (push && pop) head <= in_data;
               else if (push)   tail <= in_data;
               else if (pop)    head <= '0;
            end
            FULL: if (pop) begin
               head <= tail;
               tail <= '0;
            end
            default: begin
               head <= '0;
               tail <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/decoder3to8_stream.sv
// Streaming registered 3-to-8 decoder with sticky seen mask.
// Optional input parity check enabled by defining DECODER3TO8_STREAM_PARITY_EN.
module decoder3to8_stream
   import decoder_pkg::*;
#(
   parameter int unsigned IN_W       = DEC_IN_W,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   decoder3to8_stream_if.slave    bus,
   input  logic                   seen_clr,
   output logic [(1<<IN_W)-1:0]   seen_mask,
   output logic [1:0]             occupancy
`ifdef DECODER3TO8_STREAM_PARITY_EN
   ,
   input  logic                   in_parity,
   output logic                   parity_err
`endif
);

   localparam int unsigned OUT_W = 1 << IN_W;

   logic [OUT_W-1:0] dec_onehot;
   logic [OUT_W-1:0] head_onehot;
   logic             parity_ok;
   logic             buf_in_valid;
   logic             buf_in_ready;
   logic             buf_out_valid;
   logic             out_xfer;

   generate
      if (IN_W == DEC_IN_W) begin : g_pkg_dec
         assign dec_onehot = OUT_W'(onehot_of(DEC_IN_W'(bus.in_code)));
      end else begin : g_gen_dec
         assign dec_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << bus.in_code;
      end
   endgenerate

`ifdef DECODER3TO8_STREAM_PARITY_EN
   // Bad-parity codes still complete the handshake but are never enqueued.
   assign parity_ok = ~(^{bus.in_code, in_parity});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= bus.in_valid & buf_in_ready & ~parity_ok;
   end
`else
   assign parity_ok = 1'b1;
`endif

   assign buf_in_valid = bus.in_valid & parity_ok;

   dec_skid_buf2 #(.W(OUT_W)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (buf_in_valid),
      .in_ready  (buf_in_ready),
      .in_data   (dec_onehot),
      .out_valid (buf_out_valid),
      .out_ready (bus.out_ready),
      .out_data  (head_onehot),
      .occupancy (occupancy)
   );

   assign bus.in_ready   = buf_in_ready;
   assign bus.out_valid  = buf_out_valid;
   assign bus.out_onehot = ACTIVE_LOW ? ~head_onehot : head_onehot;
   assign out_xfer       = buf_out_valid & bus.out_ready;

   // A coincident clear still keeps the bit being delivered this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           seen_mask <= '0;
      else if (out_xfer) seen_mask <= (seen_clr ? '0 : seen_mask) | head_onehot;
      else if (seen_clr) seen_mask <= '0;
   end

endmodule

// File: tb/tb_decoder3to8_stream.sv
// Directed self-checking bench for decoder3to8_stream (normal and one-cold instances).
module tb_decoder3to8_stream;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decoder3to8_stream_if #(.IN_W(3)) bus ();
   decoder3to8_stream_if #(.IN_W(3)) bus_al ();

   logic       seen_clr, seen_clr_al;
   logic [7:0] seen_mask, seen_mask_al;
   logic [1:0] occ, occ_al;
`ifdef DECODER3TO8_STREAM_PARITY_EN
   logic in_parity, parity_err, in_parity_al, parity_err_al;
`endif

   decoder3to8_stream #(.IN_W(3), .ACTIVE_LOW(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .seen_clr   (seen_clr),
      .seen_mask  (seen_mask),
      .occupancy  (occ)
`ifdef DECODER3TO8_STREAM_PARITY_EN
      ,
      .in_parity  (in_parity),
      .parity_err (parity_err)
`endif
   );

   decoder3to8_stream #(.IN_W(3), .ACTIVE_LOW(1'b1)) dut_al (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_al),
      .seen_clr   (seen_clr_al),
      .seen_mask  (seen_mask_al),
      .occupancy  (occ_al)
`ifdef DECODER3TO8_STREAM_PARITY_EN
      ,
      .in_parity  (in_parity_al),
      .parity_err (parity_err_al)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %02h exp %02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_sweep [8];

   initial begin
      exp_sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      rst = 1'b1;
      bus.in_valid = 1'b0;    bus.in_code = 3'd0;    bus.out_ready = 1'b0;
      bus_al.in_valid = 1'b0; bus_al.in_code = 3'd0; bus_al.out_ready = 1'b0;
      seen_clr = 1'b0; seen_clr_al = 1'b0;
`ifdef DECODER3TO8_STREAM_PARITY_EN
      in_parity = 1'b0; in_parity_al = 1'b0;
`endif
      step();
      step();

      chk("rst_out_valid", 8'(bus.out_valid), 8'h00);
      chk("rst_in_ready",  8'(bus.in_ready),  8'h01);
      chk("rst_occ",       8'(occ),           8'h00);
      chk("rst_seen",      seen_mask,         8'h00);
      chk("rst_onehot",    bus.out_onehot,    8'h00);
      chk("rst_al_onehot", bus_al.out_onehot, 8'hFF);
      rst = 1'b0;

      // Sweep all codes back-to-back with downstream always ready.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_code  = 3'(i);
         step();
         chk("sweep_onehot", bus.out_onehot, exp_sweep[i]);
         chk("sweep_occ",    8'(occ),        8'h01);
      end
      bus.in_valid = 1'b0;
      step();
      chk("sweep_seen",  seen_mask,          8'hFF);
      chk("sweep_drain", 8'(occ),            8'h00);
      chk("sweep_idle",  bus.out_onehot,     8'h00);

      // Backpressure: 3 and 5 accepted, 6 stalls until space frees.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_code   = 3'd3;
      step();
      chk("bp_occ1",  8'(occ),           8'h01);
      chk("bp_rdy1",  8'(bus.in_ready),  8'h01);
      bus.in_code = 3'd5;
      step();
      chk("bp_occ2",  8'(occ),           8'h02);
      chk("bp_rdy2",  8'(bus.in_ready),  8'h00);
      chk("bp_head",  bus.out_onehot,    8'h08);
      bus.in_code = 3'd6;
      step();
      chk("bp_hold_occ",  8'(occ),        8'h02);
      chk("bp_hold_head", bus.out_onehot, 8'h08);
      chk("bp_hold_vld",  8'(bus.out_valid), 8'h01);
      bus.out_ready = 1'b1;
      step();
      chk("rel_1", bus.out_onehot, 8'h20);
      chk("rel_1_occ", 8'(occ), 8'h01);
      step();
      chk("rel_2", bus.out_onehot, 8'h40);
      chk("rel_2_occ", 8'(occ), 8'h01);
      bus.in_valid = 1'b0;
      step();
      chk("rel_empty_vld", 8'(bus.out_valid), 8'h00);
      chk("rel_empty_occ", 8'(occ), 8'h00);

      // Clear with no output transfer.
      seen_clr = 1'b1;
      step();
      seen_clr = 1'b0;
      chk("clr_alone", seen_mask, 8'h00);

      // Clear coinciding with delivery of code 2 keeps only that bit.
      bus.in_valid = 1'b1;
      bus.in_code  = 3'd5;
      step();
      bus.in_valid = 1'b0;
      step();
      chk("pre_clr_seen", seen_mask, 8'h20);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_code   = 3'd2;
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      seen_clr      = 1'b1;
      step();
      seen_clr = 1'b0;
      chk("clr_xfer", seen_mask, 8'h04);

      // Asynchronous reset with two words buffered.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_code   = 3'd1;
      step();
      bus.in_code   = 3'd2;
      step();
      bus.in_valid  = 1'b0;
      chk("pre_rst_occ", 8'(occ), 8'h02);
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 8'(bus.out_valid), 8'h00);
      chk("arst_in_ready",  8'(bus.in_ready),  8'h01);
      chk("arst_seen",      seen_mask,         8'h00);
      chk("arst_occ",       8'(occ),           8'h00);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_onehot", bus.out_onehot, 8'h00);

      // One-cold instance.
      bus_al.out_ready = 1'b1;
      bus_al.in_valid  = 1'b1;
      bus_al.in_code   = 3'd0;
      step();
      chk("al_onehot", bus_al.out_onehot, 8'hFE);
      bus_al.in_valid = 1'b0;
      step();
      chk("al_seen",  seen_mask_al,      8'h01);
      chk("al_idle",  bus_al.out_onehot, 8'hFF);

`ifdef DECODER3TO8_STREAM_PARITY_EN
      // Code 3 has two ones, so a parity bit of 0 keeps the total even.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_code   = 3'd3;
      in_parity     = 1'b0;
      step();
      chk("par_good",     bus.out_onehot,  8'h08);
      chk("par_good_err", 8'(parity_err),  8'h00);
      in_parity = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("par_bad_err", 8'(parity_err), 8'h01);
      chk("par_bad_occ", 8'(occ),        8'h01);
      step();
      chk("par_err_pulse", 8'(parity_err), 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
